// File: rtl/zork_text_pkg.sv
// -----------------------------------------------------------------------------
// zork_text_pkg
// Shared constants for the text-window front end: VGA coordinate width, the
// ASCII codes the window substitutes, default glyph geometry and a helper that
// gives the pixel extent of a character grid along one axis.
// -----------------------------------------------------------------------------
package zork_text_pkg;

  localparam int VGA_COORD_W = 10;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_NUL   = 8'h00;

  // Default glyph cell: 8 x 16 pixels.
  localparam int DEF_CHAR_W_LOG2 = 3;
  localparam int DEF_CHAR_H_LOG2 = 4;

  // Pixel extent of 2**cells_log2 glyphs, each 2**px_log2 pixels wide/high.
  function automatic int win_extent(input int cells_log2, input int px_log2);
    return 1 << (cells_log2 + px_log2);
  endfunction

endpackage

// File: rtl/text_reveal_window_reveal_counter.sv
// -----------------------------------------------------------------------------
// reveal_counter
// Typewriter reveal state: counts vsync falling edges, advances the number of
// revealed characters once every FRAMES_PER_CHAR frames, restarts on a room
// change and jumps straight to "all revealed" on a skip pulse.
//
// Ports
//   clk         system clock
//   rst_n       synchronous reset, active low
//   room        current room number
//   skip        one-cycle pulse, reveal everything
//   vsync       vertical sync, active low
//   reveal_cnt  number of revealed characters, 0 .. 2**N_LOG2
//   reveal_done registered (reveal_cnt == 2**N_LOG2)
// -----------------------------------------------------------------------------
module reveal_counter #(
  parameter int N_LOG2          = 8,
  parameter int FRAMES_PER_CHAR = 2,
  parameter int ROOM_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROOM_W-1:0] room,
  input  logic              skip,
  input  logic              vsync,
  output logic [N_LOG2:0]   reveal_cnt,
  output logic              reveal_done
);

  // A 1-frame reveal still needs a 1-bit counter that simply stays at zero.
  localparam int FC_W = (FRAMES_PER_CHAR > 1) ? $clog2(FRAMES_PER_CHAR) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_CHAR - 1);
  localparam logic [N_LOG2:0] MAX     = {1'b1, {N_LOG2{1'b0}}};

  logic              vsync_q;
  logic [ROOM_W-1:0] room_q;
  logic [FC_W-1:0]   frame_cnt, frame_cnt_nxt;
  logic [N_LOG2:0]   reveal_cnt_nxt;
  logic              tick;

  assign tick = vsync_q & ~vsync;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    frame_cnt_nxt  = frame_cnt;
    reveal_cnt_nxt = reveal_cnt;
    if (room != room_q) begin
      frame_cnt_nxt  = '0;
      reveal_cnt_nxt = '0;
    end else if (skip) begin
      reveal_cnt_nxt = MAX;
    end else if (tick) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt_nxt = '0;
        if (reveal_cnt != MAX) reveal_cnt_nxt = reveal_cnt + 1'b1;
      end else begin
        frame_cnt_nxt = frame_cnt + 1'b1;
      end
    end
  end

  // NOTE: the reset is sampled inside the clocked block (synchronous), so it
  // only takes effect at a clock edge and never appears in the sensitivity list.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      vsync_q     <= 1'b1;
      room_q      <= '0;
      frame_cnt   <= '0;
      reveal_cnt  <= '0;
      reveal_done <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      room_q      <= room;
      frame_cnt   <= frame_cnt_nxt;
      reveal_cnt  <= reveal_cnt_nxt;
      reveal_done <= (reveal_cnt == MAX);
    end
  end

endmodule

// File: rtl/text_reveal_window.sv
// -----------------------------------------------------------------------------
// text_reveal_window
// Text-window front end between VGA timing, the character RAM and the glyph
// driver. Maps the pixel position onto a character grid starting at pixel row
// ORIGIN_Y, issues the RAM address {room, row, col}, and delays glyph offsets
// and window/reveal flags to line up with the one-cycle RAM read. Characters
// appear typewriter style under control of reveal_counter.
//
// Ports
//   clk_50MHz_i     system clock
//   rst_sync_la_i   synchronous reset, active low
//   room_i          current room
//   skip_i          one-cycle pulse, reveal all characters
//   vga_x_i/_y_i    pixel column / row
//   vga_vsync_i     vertical sync, active low
//   ram_addr_o      character RAM address {room, row, col}
//   ram_data_i      ASCII from RAM, valid one cycle after ram_addr_o
//   char_ascii_o    character for the glyph driver (space when hidden)
//   glyph_x_o/_y_o  pixel offset inside the glyph
//   char_visible_o  pixel is in a revealed, non-NUL character in the window
//   reveal_done_o   every window character is revealed
// Coordinate to glyph outputs latency: 3 cycles.
// -----------------------------------------------------------------------------
module text_reveal_window
  import zork_text_pkg::*;
#(
  parameter int CHAR_W_LOG2     = DEF_CHAR_W_LOG2,
  parameter int CHAR_H_LOG2     = DEF_CHAR_H_LOG2,
  parameter int COLS_LOG2       = 6,
  parameter int ROWS_LOG2       = 2,
  parameter int ORIGIN_Y        = 0,
  parameter int ROOM_W          = 8,
  parameter int FRAMES_PER_CHAR = 2
) (
  input  logic                                  clk_50MHz_i,
  input  logic                                  rst_sync_la_i,
  input  logic [ROOM_W-1:0]                     room_i,
  input  logic                                  skip_i,
  input  logic [VGA_COORD_W-1:0]                vga_x_i,
  input  logic [VGA_COORD_W-1:0]                vga_y_i,
  input  logic                                  vga_vsync_i,
  output logic [ROOM_W+ROWS_LOG2+COLS_LOG2-1:0] ram_addr_o,
  input  logic [7:0]                            ram_data_i,
  output logic [7:0]                            char_ascii_o,
  output logic [CHAR_W_LOG2-1:0]                glyph_x_o,
  output logic [CHAR_H_LOG2-1:0]                glyph_y_o,
  output logic                                  char_visible_o,
  output logic                                  reveal_done_o
);

  localparam int N_LOG2 = ROWS_LOG2 + COLS_LOG2;
  localparam logic [VGA_COORD_W-1:0] ORIGIN = VGA_COORD_W'(ORIGIN_Y);
  // One extra bit so an extent of 1024 pixels still compares correctly.
  localparam logic [VGA_COORD_W:0] WIN_W =
    (VGA_COORD_W + 1)'(win_extent(COLS_LOG2, CHAR_W_LOG2));
  localparam logic [VGA_COORD_W:0] WIN_H =
    (VGA_COORD_W + 1)'(win_extent(ROWS_LOG2, CHAR_H_LOG2));

  logic [N_LOG2:0]          reveal_cnt;
  logic [VGA_COORD_W-1:0]   rel_y;
  logic [COLS_LOG2-1:0]     col;
  logic [ROWS_LOG2-1:0]     row;
  logic                     in_win;
  logic                     rev_ok;
  logic                     show;

  // Stage 1 / stage 2 delay registers for glyph offsets and flags.
  logic [CHAR_W_LOG2-1:0]   gx1, gx2;
  logic [CHAR_H_LOG2-1:0]   gy1, gy2;
  logic                     win1, win2;
  logic                     rev1, rev2;

  reveal_counter #(
    .N_LOG2          (N_LOG2),
    .FRAMES_PER_CHAR (FRAMES_PER_CHAR),
    .ROOM_W          (ROOM_W)
  ) u_reveal (
    .clk         (clk_50MHz_i),
    .rst_n       (rst_sync_la_i),
    .room        (room_i),
    .skip        (skip_i),
    .vsync       (vga_vsync_i),
    .reveal_cnt  (reveal_cnt),
    .reveal_done (reveal_done_o)
  );

  // Rows above the origin wrap rel_y to a large value; the explicit
  // vga_y_i >= ORIGIN term keeps them out regardless.
  assign rel_y  = vga_y_i - ORIGIN;
  assign col    = vga_x_i[CHAR_W_LOG2 +: COLS_LOG2];
  assign row    = rel_y[CHAR_H_LOG2 +: ROWS_LOG2];
  assign in_win = (vga_y_i >= ORIGIN) && ({1'b0, rel_y} < WIN_H)
                  && ({1'b0, vga_x_i} < WIN_W);
  assign rev_ok = ({1'b0, row, col} < reveal_cnt);

  // RAM data is only meaningful during stage 2, aligned with win2/rev2.
  assign show = win2 & rev2 & (ram_data_i != ASCII_NUL);

  always_ff @(posedge clk_50MHz_i) begin
    if (!rst_sync_la_i) begin
      ram_addr_o     <= '0;
      gx1            <= '0;
      gy1            <= '0;
      win1           <= 1'b0;
      rev1           <= 1'b0;
      gx2            <= '0;
      gy2            <= '0;
      win2           <= 1'b0;
      rev2           <= 1'b0;
      char_ascii_o   <= ASCII_SPACE;
      glyph_x_o      <= '0;
      glyph_y_o      <= '0;
      char_visible_o <= 1'b0;
    end else begin
      // Stage 1: address and sampled geometry.
      ram_addr_o     <= {room_i, row, col};
      gx1            <= vga_x_i[CHAR_W_LOG2-1:0];
      gy1            <= rel_y[CHAR_H_LOG2-1:0];
      win1           <= in_win;
      rev1           <= rev_ok;
      // Stage 2: wait out the RAM read.
      gx2            <= gx1;
      gy2            <= gy1;
      win2           <= win1;
      rev2           <= rev1;
      // Stage 3: outputs to the glyph driver.
      char_visible_o <= show;
      char_ascii_o   <= show ? ram_data_i : ASCII_SPACE;
      glyph_x_o      <= gx2;
      glyph_y_o      <= gy2;
    end
  end

endmodule

// File: tb/tb_text_reveal_window.sv
// -----------------------------------------------------------------------------
// tb_text_reveal_window
// Two instances share stimulus: dut_a with default geometry, dut_b with
// ORIGIN_Y=100. Each has its own behavioural character RAM with one-cycle
// read latency. Pixel expectations are queued when a coordinate is driven and
// compared three cycles later when the outputs appear.
// -----------------------------------------------------------------------------
module tb_text_reveal_window;
  import zork_text_pkg::*;

  typedef struct {
    bit         sel;    // 0: dut_a, 1: dut_b (ORIGIN_Y=100)
    logic [9:0] x;
    logic [9:0] y;
    logic       vis;
    logic [7:0] ascii;
    logic [2:0] gx;
    logic [3:0] gy;
  } vec_t;

  typedef struct {
    int         due;
    int         tag;
    bit         sel;
    logic       vis;
    logic [7:0] ascii;
    logic [2:0] gx;
    logic [3:0] gy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] room;
  logic       skip;
  logic [9:0] vx, vy;
  logic       vsync;

  logic [15:0] ram_addr_a, ram_addr_b;
  logic [7:0]  ram_data_a, ram_data_b;
  logic [7:0]  ascii_a, ascii_b;
  logic [2:0]  gx_a, gx_b;
  logic [3:0]  gy_a, gy_b;
  logic        vis_a, vis_b;
  logic        done_a, done_b;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  text_reveal_window dut_a (
    .clk_50MHz_i    (clk),
    .rst_sync_la_i  (rst_n),
    .room_i         (room),
    .skip_i         (skip),
    .vga_x_i        (vx),
    .vga_y_i        (vy),
    .vga_vsync_i    (vsync),
    .ram_addr_o     (ram_addr_a),
    .ram_data_i     (ram_data_a),
    .char_ascii_o   (ascii_a),
    .glyph_x_o      (gx_a),
    .glyph_y_o      (gy_a),
    .char_visible_o (vis_a),
    .reveal_done_o  (done_a)
  );

  text_reveal_window #(.ORIGIN_Y(100)) dut_b (
    .clk_50MHz_i    (clk),
    .rst_sync_la_i  (rst_n),
    .room_i         (room),
    .skip_i         (skip),
    .vga_x_i        (vx),
    .vga_y_i        (vy),
    .vga_vsync_i    (vsync),
    .ram_addr_o     (ram_addr_b),
    .ram_data_i     (ram_data_b),
    .char_ascii_o   (ascii_b),
    .glyph_x_o      (gx_b),
    .glyph_y_o      (gy_b),
    .char_visible_o (vis_b),
    .reveal_done_o  (done_b)
  );

  // Character RAM contents: column 3 holds NUL, others 'A' + (col mod 16).
  function automatic logic [7:0] ram_model(input logic [15:0] addr);
    logic [5:0] c;
    c = addr[5:0];
    return (c == 6'd3) ? 8'h00 : 8'h41 + {4'b0, c[3:0]};
  endfunction

  always @(posedge clk) begin
    ram_data_a <= ram_model(ram_addr_a);
    ram_data_b <= ram_model(ram_addr_b);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: outputs for a coordinate driven at cycle n are
  // compared at the negedge after the third following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (!e.sel) begin
        check($sformatf("px%0d_vis", e.tag),   32'(vis_a),   32'(e.vis));
        check($sformatf("px%0d_ascii", e.tag), 32'(ascii_a), 32'(e.ascii));
        check($sformatf("px%0d_gx", e.tag),    32'(gx_a),    32'(e.gx));
        check($sformatf("px%0d_gy", e.tag),    32'(gy_a),    32'(e.gy));
      end else begin
        check($sformatf("px%0d_vis", e.tag),   32'(vis_b),   32'(e.vis));
        check($sformatf("px%0d_ascii", e.tag), 32'(ascii_b), 32'(e.ascii));
        check($sformatf("px%0d_gx", e.tag),    32'(gx_b),    32'(e.gx));
        check($sformatf("px%0d_gy", e.tag),    32'(gy_b),    32'(e.gy));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pix(input int tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    vx = v.x;
    vy = v.y;
    e.due = cyc + 3;
    e.tag = tag;
    e.sel = v.sel;
    e.vis = v.vis;
    e.ascii = v.ascii;
    e.gx = v.gx;
    e.gy = v.gy;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic vsync_falls(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); vsync = 1'b0;
      @(negedge clk); vsync = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(ram_addr_a), 32'h0);
    check({tag, "_ascii"}, 32'(ascii_a),    32'h20);
    check({tag, "_gx"},    32'(gx_a),       32'h0);
    check({tag, "_gy"},    32'(gy_a),       32'h0);
    check({tag, "_vis"},   32'(vis_a),      32'h0);
    check({tag, "_done"},  32'(done_a),     32'h0);
    check({tag, "_cnt"},   32'(dut_a.reveal_cnt), 32'h0);
  endtask

  vec_t tbl[12];

  initial begin
    //        sel  x    y    vis ascii  gx gy
    tbl[0]  = '{0, 17,  20,  1, 8'h43, 1, 4};   // row1 col2
    tbl[1]  = '{0, 0,   0,   1, 8'h41, 0, 0};   // first cell
    tbl[2]  = '{0, 511, 63,  1, 8'h50, 7, 15};  // last cell, last pixel
    tbl[3]  = '{0, 24,  5,   0, 8'h20, 0, 5};   // col3 holds NUL
    tbl[4]  = '{0, 512, 10,  0, 8'h20, 0, 10};  // right of window
    tbl[5]  = '{0, 100, 64,  0, 8'h20, 4, 0};   // below window
    tbl[6]  = '{0, 523, 30,  0, 8'h20, 3, 14};
    tbl[7]  = '{0, 40,  17,  1, 8'h46, 0, 1};   // row1 col5
    tbl[8]  = '{1, 8,   99,  0, 8'h20, 0, 15};  // one row above origin
    tbl[9]  = '{1, 8,   100, 1, 8'h42, 0, 0};   // origin row, col1
    tbl[10] = '{1, 9,   163, 1, 8'h42, 1, 15};  // last window row
    tbl[11] = '{1, 9,   164, 0, 8'h20, 1, 0};   // first row below

    rst_n = 1'b0; room = 8'h05; skip = 1'b0;
    vx = '0; vy = '0; vsync = 1'b1;
    step(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Address mapping; nothing revealed yet so the cell is hidden.
    pix(100, '{0, 17, 20, 0, 8'h20, 1, 4});
    @(negedge clk);
    check("addr_map", 32'(ram_addr_a), 32'h0542);
    drain();

    // Reveal progression: two frames reveal exactly idx 0.
    pix(101, '{0, 0, 0, 0, 8'h20, 0, 0});
    drain();
    vsync_falls(2);
    check("cnt_after_2_frames", 32'(dut_a.reveal_cnt), 32'd1);
    pix(102, '{0, 0, 0, 1, 8'h41, 0, 0});
    pix(103, '{0, 8, 0, 0, 8'h20, 0, 0});
    drain();

    // Saturation at 256 characters (512 frames total).
    vsync_falls(510);
    step(1);
    check("cnt_saturated", 32'(dut_a.reveal_cnt), 32'd256);
    check("done_saturated", 32'(done_a), 32'd1);
    vsync_falls(10);
    step(1);
    check("cnt_hold_max", 32'(dut_a.reveal_cnt), 32'd256);
    check("done_hold_max", 32'(done_a), 32'd1);

    // Restart in room 05 and reach reveal_cnt = 100.
    room = 8'h04; step(1);
    room = 8'h05; step(1);
    check("cnt_restart", 32'(dut_a.reveal_cnt), 32'd0);
    vsync_falls(200);
    check("cnt_100", 32'(dut_a.reveal_cnt), 32'd100);
    room = 8'h06;
    step(1);
    check("room_change_cnt", 32'(dut_a.reveal_cnt), 32'd0);
    step(1);
    check("room_change_done", 32'(done_a), 32'd0);

    // Skip pulse.
    skip = 1'b1; step(1); skip = 1'b0;
    check("skip_cnt", 32'(dut_a.reveal_cnt), 32'd256);
    step(1);
    check("skip_done", 32'(done_a), 32'd1);

    // Skip together with a room change: the restart wins.
    room = 8'h07; skip = 1'b1; step(1); skip = 1'b0;
    check("skip_room_cnt", 32'(dut_a.reveal_cnt), 32'd0);
    check("skip_room_cnt_b", 32'(dut_b.reveal_cnt), 32'd0);

    // Fully revealed room 05 for the geometry table.
    room = 8'h05; step(1);
    skip = 1'b1; step(1); skip = 1'b0;
    step(1);
    check("table_setup_done", 32'(done_a), 32'd1);
    for (int i = 0; i < 12; i++) pix(i, tbl[i]);
    drain();

    // Reset mid-reveal with a visible pixel still in the pipeline.
    @(negedge clk); vx = '0; vy = '0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("flush_vis_1", 32'(vis_a), 32'd0);
    @(negedge clk);
    check("flush_vis_2", 32'(vis_a), 32'd0);
    check("flush_ascii", 32'(ascii_a), 32'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_reveal_window.md
Name: text_reveal_window

Overview:
- Parametrised text-window front end between the VGA timing generator, the labyrinth character RAM and the glyph image driver.
- Maps pixel coordinates onto a configurable character grid at a configurable vertical origin, and generates the RAM address from the room number and the character cell.
- Pipelines the coordinates to match the RAM read latency.
- Adds a typewriter reveal: one character per N frames, restarted on room change, skippable by a keypress.

Parameters:
- CHAR_W_LOG2, 3, log2 of glyph width in pixels (8).
- CHAR_H_LOG2, 4, log2 of glyph height in pixels (16).
- COLS_LOG2, 6, log2 of characters per row (64).
- ROWS_LOG2, 2, log2 of text rows (4).
- ORIGIN_Y, 0, first pixel row of the window; 10-bit value.
- ROOM_W, 8, width of the room/player-position number.
- FRAMES_PER_CHAR, 2, frames between successive reveals; must be >= 1.

Ports:
- clk_50MHz_i  in  1  system clock, 50 MHz.
- rst_sync_la_i  in  1  synchronous reset, active low.
- room_i  in  ROOM_W  current room from game control.
- skip_i  in  1  one-cycle pulse (keypad one-shot); reveal all characters.
- vga_x_i  in  10  pixel column.
- vga_y_i  in  10  pixel row.
- vga_vsync_i  in  1  vertical sync, active low.
- ram_addr_o  out  ROOM_W+ROWS_LOG2+COLS_LOG2  character RAM address = {room, row, col}.
- ram_data_i  in  8  ASCII from RAM; valid one cycle after ram_addr_o.
- char_ascii_o  out  8  character for the glyph driver.
- glyph_x_o  out  CHAR_W_LOG2  pixel column within the glyph.
- glyph_y_o  out  CHAR_H_LOG2  pixel row within the glyph.
- char_visible_o  out  1  pixel belongs to a revealed, non-NUL character inside the window.
- reveal_done_o  out  1  all window characters revealed.

Behaviour:
- Reset (rst_sync_la_i=0 at a clock edge) forces:
  - ram_addr_o=0, char_ascii_o=8'h20, glyph_x_o=0, glyph_y_o=0, char_visible_o=0, reveal_done_o=0.
  - reveal_cnt=0, frame_cnt=0, room_q=0, vsync_q=1.
  - All pipeline valid/in-window flags cleared.
- Window geometry:
  - in_win = (vga_y_i >= ORIGIN_Y) && (vga_y_i - ORIGIN_Y < ROWS<<CHAR_H_LOG2) && (vga_x_i < COLS<<CHAR_W_LOG2).
  - rel_y = vga_y_i - ORIGIN_Y, computed 10-bit unsigned.
  - col = vga_x_i >> CHAR_W_LOG2, truncated to COLS_LOG2 bits.
  - row = rel_y >> CHAR_H_LOG2, truncated to ROWS_LOG2 bits.
  - idx = {row, col}.
- Pipeline (edge E samples inputs):
  - Stage 1 @E+1:
    - ram_addr_o <= {room_i, row, col}.
    - Stage 1 also registers the glyph offsets, in_win, and rev_ok = (idx < reveal_cnt).
  - Stage 2 @E+2: ram_data_i is valid during this cycle; glyph offsets and flags are delayed.
  - Stage 3 @E+3: outputs are registered.
    - char_visible_o <= in_win & rev_ok & (ram_data_i != 8'h00).
    - char_ascii_o <= char_visible_o-condition ? ram_data_i : 8'h20.
    - glyph_x_o <= vga_x_i[CHAR_W_LOG2-1:0] delayed; glyph_y_o <= rel_y[CHAR_H_LOG2-1:0] delayed.
  - Fixed latency from coordinate to outputs: 3 cycles.
- Frame tick: tick = vsync_q & ~vga_vsync_i (falling edge); vsync_q <= vga_vsync_i every cycle.
- Reveal counter:
  - reveal_cnt is ROWS_LOG2+COLS_LOG2+1 bits; MAX = 1<<(ROWS_LOG2+COLS_LOG2).
  - Priority, highest first:
    1. room change (room_i != room_q): reveal_cnt <= 0, frame_cnt <= 0.
    2. skip_i: reveal_cnt <= MAX.
    3. tick: if frame_cnt == FRAMES_PER_CHAR-1, then frame_cnt <= 0 and reveal_cnt <= min(reveal_cnt+1, MAX); else frame_cnt++.
  - room_q <= room_i every cycle.
  - Room change together with skip in the same cycle: the room change wins and the reveal restarts.
  - At MAX, further ticks hold reveal_cnt=MAX; frame_cnt keeps cycling.
- reveal_done_o: registered; equals (reveal_cnt == MAX), i.e. the value 1 cycle later.
- Reset mid-frame or mid-reveal: state returns to reset values at that edge; in-flight pipeline data is discarded because the flags clear.

Decomposition:
- Package zork_text_pkg:
  - VGA_COORD_W=10.
  - ASCII_SPACE=8'h20, ASCII_NUL=8'h00.
  - Default glyph size constants.
  - A function for the window pixel extent.
- Sub-module reveal_counter:
  - Contains vsync edge detection, frame_cnt, reveal_cnt, room_q, the priority logic and reveal_done_o.
  - Parameters: N_LOG2, FRAMES_PER_CHAR, ROOM_W.

Test Plan:
1. Address mapping (defaults): room_i=8'h05, vga_x_i=17, vga_y_i=20 -> ram_addr_o=16'h0542 @E+1; glyph_x_o=1, glyph_y_o=4 @E+3.
2. Reveal progression: after reset, RAM returns 8'h41 at idx 0. No vsync fall -> char_visible_o=0, char_ascii_o=8'h20. After 2 vsync falls -> reveal_cnt=1; idx 0 gives char_visible_o=1, char_ascii_o=8'h41; idx 1 stays hidden.
3. Saturation: 512 vsync falls -> reveal_cnt=256, reveal_done_o=1. A further 10 falls leave reveal_cnt=256.
4. Room change and skip:
   - At reveal_cnt=100, change room_i 05->06 -> reveal_cnt=0 next edge, reveal_done_o=0.
   - skip_i pulse -> reveal_cnt=256 and reveal_done_o=1 within 2 cycles.
   - skip_i and room change in the same cycle -> reveal_cnt=0.
5. Window bounds: vga_y_i=64 or vga_x_i=512 -> char_visible_o=0, char_ascii_o=8'h20. With ORIGIN_Y=100, vga_y_i=99 is outside the window and vga_y_i=100 is row 0.
6. NUL handling and reset: with ram_data_i=8'h00 in a revealed cell -> visible=0, ascii=8'h20. Assert rst_sync_la_i=0 mid-reveal -> all outputs return to their reset values at that edge.
